// File: rtl/bram_port_arbiter.sv
// Purpose: shares one frame-BRAM port between display reads (priority) and a frame-update writer.
// Latency: grant -> BRAM port 1 cycle; read grant -> DISP_RVALID/DISP_RDATA 2+RD_LAT cycles.
// Backpressure: requesters hold REQ/address/data until GNT; a granted slot cannot be refused.
// Build option: define BRAM_ARB_STARVE_GUARD_EN to add the writer wait counter and forced write slot.
module bram_port_arbiter #(
   parameter int AW       = 17,
   parameter int DW       = 24,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 15
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          DISP_REQ,
   input  logic [AW-1:0] DISP_ADDR,
   output logic          DISP_GNT,
   output logic [DW-1:0] DISP_RDATA,
   output logic          DISP_RVALID,
   input  logic          WR_REQ,
   input  logic [AW-1:0] WR_ADDR,
   input  logic [DW-1:0] WR_DATA,
   output logic          WR_GNT,
   output logic          BRAM_EN,
   output logic          BRAM_WE,
   output logic [AW-1:0] BRAM_ADDR,
   output logic [DW-1:0] BRAM_WDATA,
   input  logic [DW-1:0] BRAM_RDATA,
   output logic [1:0]    OWNER
);

   localparam logic [1:0] OWN_IDLE = 2'd0;
   localparam logic [1:0] OWN_DISP = 2'd1;
   localparam logic [1:0] OWN_WR   = 2'd2;

   // Out-of-range parameters elaborate this marker block so they stand out in the hierarchy.
   if (RD_LAT < 1 || RD_LAT > 4 || MAX_WAIT < 1) begin : g_illegal_config
   end

   logic          force_wr;
   logic          disp_gnt;
   logic          wr_gnt;

   logic          bram_en_q,    bram_en_d;
   logic          bram_we_q,    bram_we_d;
   logic [AW-1:0] bram_addr_q,  bram_addr_d;
   logic [DW-1:0] bram_wdata_q, bram_wdata_d;
   logic [1:0]    owner_q,      owner_d;
   logic [RD_LAT:0] rd_pipe_q,  rd_pipe_d;
   logic          disp_rvalid_q, disp_rvalid_d;
   logic [DW-1:0] disp_rdata_q,  disp_rdata_d;

`ifdef BRAM_ARB_STARVE_GUARD_EN
   localparam int WCW = $clog2(MAX_WAIT + 1);
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

   // Writer wait counter: counts contested cycles, cleared when the writer is served or idle.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!WR_REQ || wr_gnt) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WCW'(MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + WCW'(1);
      end
   end

   // Wait counter register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`endif

   // Grant decision: display wins unless the starvation guard forces a write slot.
   // Grants are held off during reset so no request is accepted and then discarded.
   always_comb begin
      force_wr = 1'b0;
`ifdef BRAM_ARB_STARVE_GUARD_EN
      force_wr = WR_REQ && (wait_cnt_q == WCW'(MAX_WAIT));
`endif
      disp_gnt = !RESET && DISP_REQ && !force_wr;
      wr_gnt   = !RESET && WR_REQ && (!DISP_REQ || force_wr);
   end

   // Next BRAM port state and read-return tracking from this cycle's grant.
   always_comb begin
      bram_en_d    = 1'b0;
      bram_we_d    = 1'b0;
      bram_addr_d  = bram_addr_q;
      bram_wdata_d = bram_wdata_q;
      owner_d      = OWN_IDLE;
      if (disp_gnt) begin
         bram_en_d   = 1'b1;
         bram_addr_d = DISP_ADDR;
         owner_d     = OWN_DISP;
      end else if (wr_gnt) begin
         bram_en_d    = 1'b1;
         bram_we_d    = 1'b1;
         bram_addr_d  = WR_ADDR;
         bram_wdata_d = WR_DATA;
         owner_d      = OWN_WR;
      end
      // Bit k is set k+1 cycles after a read grant; the top bit lines up with valid BRAM_RDATA.
      rd_pipe_d     = {rd_pipe_q[RD_LAT-1:0], disp_gnt};
      disp_rvalid_d = rd_pipe_q[RD_LAT];
      disp_rdata_d  = rd_pipe_q[RD_LAT] ? BRAM_RDATA : disp_rdata_q;
   end

   // Port, owner and return registers; reset flushes in-flight reads.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         bram_en_q     <= 1'b0;
         bram_we_q     <= 1'b0;
         bram_addr_q   <= '0;
         bram_wdata_q  <= '0;
         owner_q       <= OWN_IDLE;
         rd_pipe_q     <= '0;
         disp_rvalid_q <= 1'b0;
         disp_rdata_q  <= '0;
      end else begin
         bram_en_q     <= bram_en_d;
         bram_we_q     <= bram_we_d;
         bram_addr_q   <= bram_addr_d;
         bram_wdata_q  <= bram_wdata_d;
         owner_q       <= owner_d;
         rd_pipe_q     <= rd_pipe_d;
         disp_rvalid_q <= disp_rvalid_d;
         disp_rdata_q  <= disp_rdata_d;
      end
   end

   assign DISP_GNT    = disp_gnt;
   assign WR_GNT      = wr_gnt;
   assign BRAM_EN     = bram_en_q;
   assign BRAM_WE     = bram_we_q;
   assign BRAM_ADDR   = bram_addr_q;
   assign BRAM_WDATA  = bram_wdata_q;
   assign OWNER       = owner_q;
   assign DISP_RVALID = disp_rvalid_q;
   assign DISP_RDATA  = disp_rdata_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: random and directed traffic against a transaction-level model.
// Latency: model predicts grants per cycle and read returns 2+RD_LAT cycles after grant.
// Backpressure: requesters hold requests until the model says they were granted.
module tb_bram_port_arbiter;
   localparam int AW = 17;
   localparam int DW = 24;
   localparam int RD_LAT = 1;
   localparam int MAX_WAIT = 15;
`ifdef BRAM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          CLK, RESET;
   logic          DISP_REQ, DISP_GNT, DISP_RVALID;
   logic [AW-1:0] DISP_ADDR;
   logic [DW-1:0] DISP_RDATA;
   logic          WR_REQ, WR_GNT;
   logic [AW-1:0] WR_ADDR;
   logic [DW-1:0] WR_DATA;
   logic          BRAM_EN, BRAM_WE;
   logic [AW-1:0] BRAM_ADDR;
   logic [DW-1:0] BRAM_WDATA, BRAM_RDATA;
   logic [1:0]    OWNER;

   bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
      .CLK(CLK), .RESET(RESET),
      .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_GNT(DISP_GNT),
      .DISP_RDATA(DISP_RDATA), .DISP_RVALID(DISP_RVALID),
      .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_GNT(WR_GNT),
      .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR),
      .BRAM_WDATA(BRAM_WDATA), .BRAM_RDATA(BRAM_RDATA), .OWNER(OWNER)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] pat(input int a);
      return DW'((a * 32'h0001_0307) ^ 32'h005A_A5C3);
   endfunction

   // Behavioural BRAM attached to the port; unread cycles present a junk value.
   logic [DW-1:0] bram_mem [1024];
   bit            written  [1024];
   logic [DW-1:0] bq       [RD_LAT];
   always @(posedge CLK) begin
      if (BRAM_EN && BRAM_WE) begin
         bram_mem[BRAM_ADDR[9:0]] <= BRAM_WDATA;
         written[BRAM_ADDR[9:0]]  <= 1'b1;
      end
      if (BRAM_EN && !BRAM_WE)
         bq[0] <= written[BRAM_ADDR[9:0]] ? bram_mem[BRAM_ADDR[9:0]] : pat(int'(BRAM_ADDR[9:0]));
      else
         bq[0] <= 24'hDEAD5A;
      for (int i = 1; i < RD_LAT; i++) bq[i] <= bq[i-1];
   end
   assign BRAM_RDATA = bq[RD_LAT-1];

   // Reference model state.
   typedef struct { int due; logic [DW-1:0] dat; } ret_t;
   ret_t          rq[$];
   logic [DW-1:0] ref_mem [1024];
   int            m_wait;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_rdata;
   int            cyc, n_chk, n_err, rv_cnt;
   bit            g_dg, g_wg, obs_wg;

   // Requester-side stimulus.
   bit            d_req, w_req;
   logic [AW-1:0] d_addr, w_addr;
   logic [DW-1:0] w_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, check grants, advance the model, check registered outputs.
   task automatic tick(input bit rst);
      bit frc, dg, wg, rv;
      RESET = rst; DISP_REQ = d_req; DISP_ADDR = d_addr;
      WR_REQ = w_req; WR_ADDR = w_addr; WR_DATA = w_data;
      #1;
      frc = GUARD && w_req && (m_wait == MAX_WAIT);
      dg  = !rst && d_req && !frc;
      wg  = !rst && w_req && (!d_req || frc);
      chk("disp_gnt", 32'(DISP_GNT), 32'(dg));
      chk("wr_gnt", 32'(WR_GNT), 32'(wg));
      obs_wg = WR_GNT;
      if (rst) begin
         m_wait = 0; rq.delete(); e_addr = '0; e_wdata = '0; e_rdata = '0;
      end else begin
         if (!w_req || wg) m_wait = 0;
         else if (m_wait < MAX_WAIT) m_wait++;
         if (dg) begin
            rq.push_back('{cyc + 2 + RD_LAT, ref_mem[d_addr[9:0]]});
            e_addr = d_addr;
         end
         if (wg) begin
            ref_mem[w_addr[9:0]] = w_data;
            e_addr = w_addr; e_wdata = w_data;
         end
      end
      @(posedge CLK);
      cyc++;
      #1;
      chk("bram_en", 32'(BRAM_EN), 32'(dg || wg));
      chk("bram_we", 32'(BRAM_WE), 32'(wg));
      chk("bram_addr", 32'(BRAM_ADDR), 32'(e_addr));
      chk("owner", 32'(OWNER), dg ? 32'd1 : (wg ? 32'd2 : 32'd0));
      if (wg || rst) chk("bram_wdata", 32'(BRAM_WDATA), 32'(e_wdata));
      rv = (rq.size() > 0) && (rq[0].due == cyc);
      if (rv) begin
         e_rdata = rq[0].dat;
         void'(rq.pop_front());
      end
      chk("disp_rvalid", 32'(DISP_RVALID), 32'(rv));
      chk("disp_rdata", 32'(DISP_RDATA), 32'(e_rdata));
      if (DISP_RVALID) rv_cnt++;
      g_dg = dg; g_wg = wg;
   endtask

   task automatic idle(input int n);
      d_req = 0; w_req = 0;
      for (int i = 0; i < n; i++) tick(0);
   endtask

   // Both requesters held; each advances to a fresh transaction once the model grants it.
   task automatic contend(input bit rst);
      d_req = 1; w_req = 1;
      tick(rst);
      if (g_dg) d_addr = AW'((int'(d_addr) + 1) % 1024);
      if (g_wg) begin w_addr = AW'($urandom_range(0, 1023)); w_data = DW'($urandom); end
   endtask

   initial begin
      int wr_cnt, first;
      bit rst;
      n_chk = 0; n_err = 0; cyc = 0; rv_cnt = 0; m_wait = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
      d_req = 0; w_req = 0; d_addr = '0; w_addr = '0; w_data = '0;

      // Reset, then reset again while a read burst is in flight.
      tick(1); tick(1);
      d_req = 1;
      for (int i = 0; i < 3; i++) begin d_addr = AW'(i + 40); tick(0); end
      tick(1); tick(1);
      idle(6);

      // Display-only burst, addresses 0..7.
      for (int i = 0; i < 8; i++) begin d_req = 1; d_addr = AW'(i); tick(0); end
      idle(6);

      // Writer-only burst of red pixels, then read them back.
      for (int i = 0; i < 4; i++) begin
         w_req = 1; w_addr = AW'(32'h100 + i); w_data = 24'hFF0000; tick(0);
      end
      w_req = 0;
      for (int i = 0; i < 4; i++) begin d_req = 1; d_addr = AW'(32'h100 + i); tick(0); end
      idle(6);

      // Sustained contention for 100 cycles.
      wr_cnt = 0; rv_cnt = 0; d_addr = AW'(200); w_addr = AW'(600); w_data = 24'h123456;
      for (int k = 0; k < 100; k++) begin
         contend(0);
         if (obs_wg) wr_cnt++;
      end
      idle(6);
      chk("contend_wr_grants", 32'(wr_cnt), GUARD ? 32'd6 : 32'd0);
      chk("contend_reads_returned", 32'(rv_cnt), GUARD ? 32'd94 : 32'd100);

      // Reset while the writer has waited 10 contested cycles.
      for (int k = 0; k < 10; k++) contend(0);
      contend(1);
      first = -1;
      for (int k = 0; k < 40; k++) begin
         contend(0);
         if (obs_wg && first < 0) first = k;
      end
      chk("force_after_reset", 32'(first), GUARD ? 32'd15 : 32'hFFFF_FFFF);
      idle(6);

      // Random traffic with occasional resets.
      for (int k = 0; k < 600; k++) begin
         if (!d_req || g_dg) begin
            d_req = ($urandom_range(0, 99) < 70); d_addr = AW'($urandom_range(0, 1023));
         end
         if (!w_req || g_wg) begin
            w_req = ($urandom_range(0, 99) < 40); w_addr = AW'($urandom_range(0, 1023));
            w_data = DW'($urandom);
         end
         rst = ($urandom_range(0, 99) == 0);
         tick(rst);
      end
      idle(8);
      chk("returns_drained", 32'(rq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

- Shares the single BRAM port between two requesters: the display fetch path (pixel reads for scan-out) and a frame-update writer.
- Sits between the BRAM controller's address generation and the frame BRAM.
- Display reads have strict priority. An optional starvation guard forces periodic write slots.
- Drives registered BRAM port signals and returns read data to the display with a fixed latency.

## Interface
- AW, 17: BRAM address width.
- DW, 24: data width ({R,G,B}, 8 bits each).
- RD_LAT, 1: BRAM read latency, in cycles from BRAM_EN to BRAM_RDATA valid; range 1–4.
- MAX_WAIT, 15: writer wait threshold for the starvation guard; minimum 1.

- CLK in 1: single clock for all logic.
- RESET in 1: synchronous, active-high.
- DISP_REQ in 1: display read request; held with DISP_ADDR until granted.
- DISP_ADDR in AW: display read address.
- DISP_GNT out 1: read accepted this cycle.
- DISP_RDATA out DW: returned pixel data.
- DISP_RVALID out 1: DISP_RDATA valid, one-cycle pulse per accepted read.
- WR_REQ in 1: write request; held with WR_ADDR/WR_DATA until granted.
- WR_ADDR in AW: write address.
- WR_DATA in DW: write data.
- WR_GNT out 1: write accepted this cycle.
- BRAM_EN out 1, BRAM_WE out 1, BRAM_ADDR out AW, BRAM_WDATA out DW: registered BRAM port.
- BRAM_RDATA in DW: BRAM read data.
- OWNER out 2: registered owner of the last issued slot: 0 idle, 1 display, 2 writer.

## Operation
- Handshake is valid/ready:
  - A request is accepted in the cycle where REQ and GNT are both 1.
  - Requesters must hold REQ and address/data stable until granted.
  - GNT is combinational from the current-cycle REQs and the wait counter.
- Arbitration, with force = guard enabled && WR_REQ && wait_cnt == MAX_WAIT:
  - DISP_GNT = DISP_REQ && !force.
  - WR_GNT = WR_REQ && (!DISP_REQ || force).
  - If neither requester is granted, the slot is idle.
- Wait counter, width clog2(MAX_WAIT+1), updated each cycle:
  - Cleared if !WR_REQ or WR_GNT.
  - Otherwise incremented, saturating at MAX_WAIT.
- Issue: the cycle after a grant, BRAM_EN=1.
  - Read: BRAM_WE=0, BRAM_ADDR=DISP_ADDR.
  - Write: BRAM_WE=1, BRAM_ADDR=WR_ADDR, BRAM_WDATA=WR_DATA.
  - Idle slot: BRAM_EN=0, BRAM_WE=0; BRAM_ADDR and BRAM_WDATA hold their previous values.
- Read return:
  - A valid-bit shift pipeline of depth 1+RD_LAT tracks in-flight reads.
  - At the tap, BRAM_RDATA is captured into DISP_RDATA and DISP_RVALID pulses.
  - DISP_RDATA holds its value between pulses.
  - Returns are strictly in order; there is no reordering.
- OWNER is updated every cycle with the grant decision, registered alongside BRAM_EN.
- Reset (synchronous, any time, including mid-burst):
  - Next edge: all outputs 0, wait counter 0, pipeline flushed.
  - Reads in flight at reset never produce DISP_RVALID.

## Timing
- Grant in cycle t → BRAM_EN in cycle t+1 → BRAM_RDATA valid in cycle t+1+RD_LAT → DISP_RDATA/DISP_RVALID in cycle t+2+RD_LAT. With RD_LAT=1, read latency is 3 cycles.
- Throughput: one access per cycle. Back-to-back display grants give back-to-back RVALID pulses.
- Simultaneous DISP_REQ and WR_REQ with the guard not firing: display granted, writer waits, counter increments.
- Guard fires with wait_cnt==MAX_WAIT:
  - The writer takes exactly one slot; DISP_GNT=0 that cycle and the display must hold its request.
  - The counter clears, so at least MAX_WAIT display slots separate consecutive forced writes.
- With only WR_REQ asserted, the writer is granted every cycle.
- Write/read to the same address in consecutive slots follows BRAM semantics; no bypass.

## Configuration
- BRAM_ARB_STARVE_GUARD_EN:
  - Defined: the wait counter and forced write slot are present as above.
  - Undefined: force is constant 0. The display has absolute priority and the writer can starve indefinitely while DISP_REQ is high.
  - Undefined: the wait counter is not synthesised.
  - Interface is identical in both builds.

## Test plan
- Reset: RESET high for 2 cycles during a read burst → every output is 0 the cycle after the first reset edge; no DISP_RVALID follows for the flushed reads.
- Display-only: DISP_REQ high for 8 cycles, addresses 0x00000–0x00007, RD_LAT=1 → BRAM_EN high cycles 1–8 with matching addresses; 8 RVALID pulses cycles 3–10 carrying the model BRAM contents in order.
- Writer-only: WR_REQ with 4 writes of 0xFF0000 to 0x00100–0x00103 → WR_GNT 4 consecutive cycles; BRAM_WE=1 on the next 4 cycles; OWNER=2; a readback via display returns 0xFF0000.
- Contention, guard on, MAX_WAIT=15: DISP_REQ and WR_REQ held continuously → writer granted on cycle 15, then every 16th cycle; DISP_GNT=0 only on those cycles; no read lost or reordered.
- Contention, guard off: same stimulus for 100 cycles → WR_GNT never asserts; all 100 reads return.
- Mid-request reset: WR_REQ pending with wait_cnt=10, RESET pulsed → after release, the counter restarts from 0 and the writer is forced only after 15 more contested cycles.
